pc_mem_sequencer: RTL and testbench
===================================

Name: pc_mem_sequencer

Overview:
Parametrised successor to the core's PC/address selector. It owns the program counter and drives a single shared memory port through a handshaked fetch/data sequence. It is the only master of the unified memory address bus. It applies PC updates (ALU target, +step, -step, hold) only after the instruction's optional data access completes, and it flags misaligned jump targets.

Parameters:
REG_LEN, 32, width of PC, addresses and ALU result.
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 4, increment/decrement applied by PC_P4/PC_M4.
ALIGN_BITS, 2, number of PC LSBs that must be zero for a legal jump target; 0 disables the check.

Ports:
clk  in  1  core clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
pc_sel  in  2  00 PC_ALU, 01 PC_P4, 10 PC_M4, 11 PC_OLD; sampled with step_valid.
step_valid  in  1  core finished executing current instruction; pc_sel/data_req/alu_out valid.
data_req  in  1  current instruction needs a load/store access at alu_out.
alu_out  in  REG_LEN  ALU result: data address and/or jump target.
mem_ack  in  1  memory completed the current request (same-cycle response allowed).
mem_req  out  1  request to memory.
mem_is_data  out  1  0 = instruction fetch, 1 = data access.
addr  out  REG_LEN  memory address.
pc  out  REG_LEN  current PC (registered).
instr_valid  out  1  one-cycle pulse: fetched instruction on the memory bus is valid.
data_done  out  1  one-cycle pulse: data access completed.
misalign_err  out  1  one-cycle pulse: ALU jump target rejected.
busy  out  1  high in S_FETCH and S_DATA.

Behaviour:
- Reset (async, rst=1): state is S_FETCH, pc is RESET_PC, and all latches clear. mem_req, instr_valid, data_done and misalign_err are forced to 0 while rst is high. The first request is issued in the first cycle after rst deasserts.
- FSM with 3 states, outputs decoded from state plus mem_ack (Mealy pulses):
  - S_FETCH: mem_req=1, mem_is_data=0, addr=pc. On mem_ack: instr_valid=1 in the same cycle, then go to S_EXEC.
  - S_EXEC: mem_req=0, addr=pc, and the block waits for step_valid. On step_valid it latches pc_sel, data_req and alu_out into sel_q/dreq_q/alu_q.
    - If data_req=1: go to S_DATA.
    - Otherwise: apply the PC update and go to S_FETCH.
  - S_DATA: mem_req=1, mem_is_data=1, addr=alu_q. On mem_ack: data_done=1, apply the PC update using sel_q/alu_q, then go to S_FETCH.
- mem_ack is ignored in S_EXEC. step_valid is ignored outside S_EXEC.
- PC update (single register write):
  - PC_ALU: pc <= target.
  - PC_P4: pc <= pc + PC_STEP.
  - PC_M4: pc <= pc - PC_STEP.
  - PC_OLD: pc unchanged.
  - Arithmetic is modulo 2^REG_LEN, so wrap-around is silent. For example, 0xFFFFFFFC + 4 = 0x00000000, and 0 - 4 = 0xFFFFFFFC.
- Misalignment: applies only when ALIGN_BITS>0, sel is PC_ALU, and target[ALIGN_BITS-1:0] != 0. In that case pc is held and misalign_err pulses in the update cycle. The FSM still proceeds to S_FETCH, which refetches the same PC.
- PC_ALU together with data_req: alu_q serves as both the data address and the jump target.
- Latency: with zero-wait memory (mem_ack tied high), an instruction takes 2 cycles without a data access and 3 cycles with one.
- Wait states: the block holds in S_FETCH/S_DATA with a stable addr and mem_req for as long as mem_ack stays low. There is no timeout.
- Reset mid-operation (any state): everything returns to the reset state immediately. No pulse is emitted and any pending update is discarded.
- busy is the registered state decode (S_FETCH or S_DATA).

Test Plan:
- Reset/fetch: release rst, mem_ack=1 always, step_valid with PC_P4 each time in S_EXEC -> addr sequence 0,4,8,12, instr_valid pulses every 2nd cycle, pc=12 after 3 steps.
- Data access with wait states: pc=0x10, step with data_req=1, alu_out=0x200, pc_sel=PC_P4, mem_ack delayed 3 cycles -> addr=0x200 and mem_is_data=1 for 4 cycles, data_done pulses once, pc=0x14, next fetch addr=0x14.
- Jump and misalign: PC_ALU alu_out=0x40 -> pc=0x40. Then PC_ALU alu_out=0x42 -> misalign_err 1-cycle pulse, pc stays 0x40, refetch at 0x40.
- Wrap-around: RESET_PC=0xFFFFFFFC, PC_P4 -> pc=0. Then PC_M4 -> pc=0xFFFFFFFC. PC_OLD -> pc unchanged.
- Reset mid-S_DATA: assert rst while mem_req=1, mem_is_data=1 -> mem_req drops immediately, no data_done, pc=RESET_PC, fetch at RESET_PC after release.
- Spurious inputs: mem_ack pulsed in S_EXEC and step_valid held high in S_FETCH -> no state change, no pulses, pc unchanged.

Source files
------------

// File: rtl/pc_mem_sequencer_if.sv
// ============================================================================
// Module   : pc_mem_sequencer_if
// Brief    : Core-step and shared memory port bundle for pc_mem_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_mem_sequencer_if #(
  parameter int REG_LEN = 32
);
  logic [1:0]         pc_sel;
  logic               step_valid;
  logic               data_req;
  logic [REG_LEN-1:0] alu_out;
  logic               mem_ack;
  logic               mem_req;
  logic               mem_is_data;
  logic [REG_LEN-1:0] addr;
  logic [REG_LEN-1:0] pc;
  logic               instr_valid;
  logic               data_done;
  logic               misalign_err;
  logic               busy;

  modport master (
    input  pc_sel, step_valid, data_req, alu_out, mem_ack,
    output mem_req, mem_is_data, addr, pc, instr_valid, data_done,
           misalign_err, busy
  );

  modport slave (
    output pc_sel, step_valid, data_req, alu_out, mem_ack,
    input  mem_req, mem_is_data, addr, pc, instr_valid, data_done,
           misalign_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/pc_mem_sequencer.sv
// ============================================================================
// Module   : pc_mem_sequencer
// Brief    : Program counter owner and fetch/data sequencer for one memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_mem_sequencer #(
  parameter int                 REG_LEN    = 32,
  parameter logic [REG_LEN-1:0] RESET_PC   = '0,
  parameter int                 PC_STEP    = 4,
  parameter int                 ALIGN_BITS = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  pc_mem_sequencer_if.master  bus
);

  localparam logic [REG_LEN-1:0] C_PC_STEP = REG_LEN'(PC_STEP);
  localparam logic [1:0]         C_PC_ALU  = 2'b00;
  localparam logic [1:0]         C_PC_P4   = 2'b01;
  localparam logic [1:0]         C_PC_M4   = 2'b10;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REG_LEN-1:0] r_pc;
  logic [1:0]         r_sel_q;
  logic               r_dreq_q;
  logic [REG_LEN-1:0] r_alu_q;

  logic               w_mem_req;
  logic               w_mem_is_data;
  logic [REG_LEN-1:0] w_addr;
  logic               w_instr_valid;
  logic               w_data_done;
  logic               w_latch;
  logic               w_apply;
  logic [1:0]         w_upd_sel;
  logic [REG_LEN-1:0] w_target;
  logic               w_tgt_misaligned;
  logic               w_misalign;
  logic [REG_LEN-1:0] w_pc_nxt;
  logic               w_pc_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_sel_q  <= 2'b00;
      r_dreq_q <= 1'b0;
      r_alu_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_sel_q  <= bus.pc_sel;
        r_dreq_q <= bus.data_req;
        r_alu_q  <= bus.alu_out;
      end
      if (w_pc_we) begin
        r_pc <= w_pc_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_req     = 1'b0;
    w_mem_is_data = 1'b0;
    w_addr        = r_pc;
    w_instr_valid = 1'b0;
    w_data_done   = 1'b0;
    w_latch       = 1'b0;
    w_apply       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) begin
          w_instr_valid = 1'b1;
          w_state_nxt   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.step_valid) begin
          w_latch = 1'b1;
          if (bus.data_req) begin
            w_state_nxt = S_DATA;
          end else begin
            w_apply     = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DATA: begin
        w_mem_req     = 1'b1;
        w_mem_is_data = 1'b1;
        w_addr        = r_alu_q;
        if (bus.mem_ack) begin
          w_data_done = r_dreq_q;
          w_apply     = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Update without a data access happens in the step cycle itself, so it
  // takes the live inputs; after a data access it uses the latched copies.
  always_comb begin
    w_upd_sel = r_sel_q;
    w_target  = r_alu_q;
    if (r_state == S_EXEC) begin
      w_upd_sel = bus.pc_sel;
      w_target  = bus.alu_out;
    end
  end

  generate
    if (ALIGN_BITS > 0) begin : g_align_chk
      assign w_tgt_misaligned = |w_target[ALIGN_BITS-1:0];
    end else begin : g_align_off
      assign w_tgt_misaligned = 1'b0;
    end
  endgenerate

  always_comb begin
    w_pc_nxt = r_pc;
    case (w_upd_sel)
      C_PC_ALU: w_pc_nxt = w_target;
      C_PC_P4:  w_pc_nxt = r_pc + C_PC_STEP;
      C_PC_M4:  w_pc_nxt = r_pc - C_PC_STEP;
      default:  w_pc_nxt = r_pc;
    endcase
  end

  assign w_misalign = w_apply && (w_upd_sel == C_PC_ALU) && w_tgt_misaligned;
  assign w_pc_we    = w_apply && !w_misalign;

  // Pulses and the request are masked while reset is held, since the
  // reset state itself is S_FETCH.
  assign bus.mem_req      = w_mem_req & ~rst;
  assign bus.mem_is_data  = w_mem_is_data;
  assign bus.addr         = w_addr;
  assign bus.pc           = r_pc;
  assign bus.instr_valid  = w_instr_valid & ~rst;
  assign bus.data_done    = w_data_done & ~rst;
  assign bus.misalign_err = w_misalign & ~rst;
  assign bus.busy         = (r_state == S_FETCH) || (r_state == S_DATA);

endmodule

`default_nettype wire

// File: tb/tb_pc_mem_sequencer.sv
// ============================================================================
// Module   : tb_pc_mem_sequencer
// Brief    : Directed self-checking bench for pc_mem_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_mem_sequencer;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pc_mem_sequencer_if #(.REG_LEN(32)) bus0 ();
  pc_mem_sequencer_if #(.REG_LEN(32)) bus1 ();

  pc_mem_sequencer #(
    .REG_LEN    (32),
    .RESET_PC   (32'h0000_0000),
    .PC_STEP    (4),
    .ALIGN_BITS (2)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pc_mem_sequencer #(
    .REG_LEN    (32),
    .RESET_PC   (32'hFFFF_FFFC),
    .PC_STEP    (4),
    .ALIGN_BITS (2)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic sv, input logic [1:0] sel, input logic dr,
                        input logic [31:0] alu, input logic ack);
    bus0.step_valid = sv;
    bus0.pc_sel     = sel;
    bus0.data_req   = dr;
    bus0.alu_out    = alu;
    bus0.mem_ack    = ack;
  endtask

  task automatic drive1(input logic sv, input logic [1:0] sel, input logic ack);
    bus1.step_valid = sv;
    bus1.pc_sel     = sel;
    bus1.data_req   = 1'b0;
    bus1.alu_out    = 32'h0;
    bus1.mem_ack    = ack;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive0(1'b0, 2'b01, 1'b0, 32'h0, 1'b1);
    drive1(1'b0, 2'b01, 1'b0);
    #12;
    chk("rst_mem_req", {31'd0, bus0.mem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, bus0.instr_valid}, 32'd0);
    chk("rst_pc", bus0.pc, 32'h0);
    chk("rst_pc_dut1", bus1.pc, 32'hFFFF_FFFC);

    // Zero-wait sequential fetch with PC_P4 steps
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_fetch_addr", bus0.addr, 32'(4 * i));
      chk("seq_instr_valid", {31'd0, bus0.instr_valid}, 32'd1);
      chk("seq_mem_req", {31'd0, bus0.mem_req}, 32'd1);
      next_cycle();
      drive0(1'b1, 2'b01, 1'b0, 32'h0, 1'b1);
      #1;
      chk("seq_exec_req", {31'd0, bus0.mem_req}, 32'd0);
      chk("seq_exec_iv", {31'd0, bus0.instr_valid}, 32'd0);
      chk("seq_exec_busy", {31'd0, bus0.busy}, 32'd0);
      next_cycle();
      drive0(1'b0, 2'b01, 1'b0, 32'h0, 1'b1);
      #1;
      if (i == 2) chk("seq_pc_after3", bus0.pc, 32'd12);
    end

    // Data access with three wait states: pc=0x10 now in S_FETCH
    chk("data_pre_pc", bus0.pc, 32'h10);
    next_cycle();
    drive0(1'b1, 2'b01, 1'b1, 32'h200, 1'b0);
    #1;
    chk("data_step_done", {31'd0, bus0.data_done}, 32'd0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive0(1'b0, 2'b00, 1'b0, 32'h0, (k == 3));
      #1;
      chk("data_addr", bus0.addr, 32'h200);
      chk("data_is_data", {31'd0, bus0.mem_is_data}, 32'd1);
      chk("data_mem_req", {31'd0, bus0.mem_req}, 32'd1);
      chk("data_done", {31'd0, bus0.data_done}, (k == 3) ? 32'd1 : 32'd0);
      chk("data_pc_hold", bus0.pc, 32'h10);
      next_cycle();
    end
    drive0(1'b0, 2'b01, 1'b0, 32'h0, 1'b1);
    #1;
    chk("data_post_pc", bus0.pc, 32'h14);
    chk("data_post_addr", bus0.addr, 32'h14);
    chk("data_post_is_data", {31'd0, bus0.mem_is_data}, 32'd0);
    chk("data_post_done", {31'd0, bus0.data_done}, 32'd0);

    // Legal jump to 0x40
    next_cycle();
    drive0(1'b1, 2'b00, 1'b0, 32'h40, 1'b1);
    #1;
    chk("jmp_no_err", {31'd0, bus0.misalign_err}, 32'd0);
    next_cycle();
    drive0(1'b0, 2'b00, 1'b0, 32'h0, 1'b1);
    #1;
    chk("jmp_pc", bus0.pc, 32'h40);
    chk("jmp_addr", bus0.addr, 32'h40);

    // Misaligned jump to 0x42 is rejected
    next_cycle();
    drive0(1'b1, 2'b00, 1'b0, 32'h42, 1'b1);
    #1;
    chk("mis_err_pulse", {31'd0, bus0.misalign_err}, 32'd1);
    next_cycle();
    drive0(1'b1, 2'b00, 1'b0, 32'h80, 1'b0);
    #1;
    chk("mis_err_clear", {31'd0, bus0.misalign_err}, 32'd0);
    chk("mis_pc_hold", bus0.pc, 32'h40);
    chk("mis_refetch", bus0.addr, 32'h40);

    // step_valid held in S_FETCH while memory stalls
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      chk("spur_fetch_req", {31'd0, bus0.mem_req}, 32'd1);
      chk("spur_fetch_iv", {31'd0, bus0.instr_valid}, 32'd0);
      chk("spur_fetch_pc", bus0.pc, 32'h40);
    end
    drive0(1'b0, 2'b00, 1'b0, 32'h0, 1'b1);
    #1;
    chk("spur_fetch_ack", {31'd0, bus0.instr_valid}, 32'd1);
    next_cycle();

    // mem_ack pulsed in S_EXEC is ignored
    for (int k = 0; k < 2; k++) begin
      drive0(1'b0, 2'b01, 1'b0, 32'h0, 1'b1);
      #1;
      chk("spur_exec_req", {31'd0, bus0.mem_req}, 32'd0);
      chk("spur_exec_iv", {31'd0, bus0.instr_valid}, 32'd0);
      chk("spur_exec_done", {31'd0, bus0.data_done}, 32'd0);
      chk("spur_exec_pc", bus0.pc, 32'h40);
      next_cycle();
      drive0(1'b0, 2'b01, 1'b0, 32'h0, 1'b0);
      #1;
      chk("spur_exec_busy", {31'd0, bus0.busy}, 32'd0);
      next_cycle();
    end

    // Reset asserted in the middle of a data access
    drive0(1'b1, 2'b01, 1'b1, 32'h300, 1'b0);
    next_cycle();
    drive0(1'b0, 2'b01, 1'b0, 32'h0, 1'b0);
    #1;
    chk("rmid_req_before", {31'd0, bus0.mem_req}, 32'd1);
    chk("rmid_is_data_before", {31'd0, bus0.mem_is_data}, 32'd1);
    chk("rmid_addr_before", bus0.addr, 32'h300);
    bus0.mem_ack = 1'b1;
    rst = 1'b1;
    #1;
    chk("rmid_req_drop", {31'd0, bus0.mem_req}, 32'd0);
    chk("rmid_no_done", {31'd0, bus0.data_done}, 32'd0);
    chk("rmid_pc", bus0.pc, 32'h0);
    next_cycle();
    chk("rmid_req_held", {31'd0, bus0.mem_req}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rmid_fetch_addr", bus0.addr, 32'h0);
    chk("rmid_fetch_req", {31'd0, bus0.mem_req}, 32'd1);
    chk("rmid_fetch_is_data", {31'd0, bus0.mem_is_data}, 32'd0);
    chk("rmid_fetch_iv", {31'd0, bus0.instr_valid}, 32'd1);
    drive0(1'b0, 2'b01, 1'b0, 32'h0, 1'b0);

    // Wrap-around on the second instance (RESET_PC = 0xFFFFFFFC)
    chk("wrap_start_addr", bus1.addr, 32'hFFFF_FFFC);
    drive1(1'b0, 2'b01, 1'b1);
    next_cycle();
    drive1(1'b1, 2'b01, 1'b1);
    next_cycle();
    drive1(1'b0, 2'b01, 1'b1);
    #1;
    chk("wrap_p4_pc", bus1.pc, 32'h0);
    chk("wrap_p4_addr", bus1.addr, 32'h0);
    next_cycle();
    drive1(1'b1, 2'b10, 1'b1);
    next_cycle();
    drive1(1'b0, 2'b10, 1'b1);
    #1;
    chk("wrap_m4_pc", bus1.pc, 32'hFFFF_FFFC);
    next_cycle();
    drive1(1'b1, 2'b11, 1'b1);
    next_cycle();
    drive1(1'b0, 2'b11, 1'b0);
    #1;
    chk("wrap_old_pc", bus1.pc, 32'hFFFF_FFFC);
    chk("wrap_old_addr", bus1.addr, 32'hFFFF_FFFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
